// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: keyboard keycodes, key-repeat FSM states and
// the classification of keys that auto-repeat while held.
package tetris_pkg;

  localparam logic [7:0] KEY_NONE     = 8'h00;
  localparam logic [7:0] KEY_LEFT     = 8'h04;
  localparam logic [7:0] KEY_RIGHT    = 8'h07;
  localparam logic [7:0] KEY_SOFTDROP = 8'h16;
  localparam logic [7:0] KEY_ROTATE   = 8'h1A;
  localparam logic [7:0] KEY_SWAP     = 8'h06;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT,
    HOLD
  } key_rep_state_t;

  // Movement keys auto-repeat; every other nonzero code fires once per press.
  function automatic logic is_repeatable(input logic [7:0] key);
    return (key == KEY_LEFT) || (key == KEY_RIGHT) || (key == KEY_SOFTDROP);
  endfunction

endpackage

// File: rtl/key_repeat_filter.sv
// Turns the raw held keycode into single-cycle action pulses: one pulse per
// press, plus DAS/ARR frame-timed auto-repeat for movement keys.
module key_repeat_filter
  import tetris_pkg::*;
#(
  parameter int DAS_FRAMES = 10,
  parameter int ARR_FRAMES = 3,
  parameter int CNT_W      = 6
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [7:0] keycode_in,
  input  logic       frame_tick,
  input  logic       block_input,
  output logic [7:0] keycode,
  output logic       is_repeat
);

  localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_FRAMES - 1);
  localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_FRAMES - 1);

  logic [7:0]       key_q;
  logic [7:0]       key_prev;
  key_rep_state_t   state;
  key_rep_state_t   state_next;
  logic [CNT_W-1:0] count;
  logic             count_clr;
  logic             count_inc;
  logic             emit;
  logic             emit_repeat;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      key_q    <= KEY_NONE;
      key_prev <= KEY_NONE;
      state    <= IDLE;
    end else begin
      key_q    <= keycode_in;
      key_prev <= key_q;
      state    <= state_next;
    end
  end

  // Release and new press override any state and swallow a coincident tick.
  always_comb begin
    state_next  = state;
    count_clr   = 1'b0;
    count_inc   = 1'b0;
    emit        = 1'b0;
    emit_repeat = 1'b0;
    if (key_q == KEY_NONE) begin
      state_next = IDLE;
      count_clr  = 1'b1;
    end else if (key_q != key_prev) begin
      emit       = 1'b1;
      count_clr  = 1'b1;
      state_next = is_repeatable(key_q) ? DELAY : HOLD;
    end else if (frame_tick) begin
      case (state)
        DELAY: begin
          if (count == DAS_LAST) begin
            emit        = 1'b1;
            emit_repeat = 1'b1;
            count_clr   = 1'b1;
            state_next  = REPEAT;
          end else begin
            count_inc = 1'b1;
          end
        end
        REPEAT: begin
          if (count == ARR_LAST) begin
            emit        = 1'b1;
            emit_repeat = 1'b1;
            count_clr   = 1'b1;
          end else begin
            count_inc = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (count_clr) begin
      count <= '0;
    end else if (count_inc) begin
      count <= count + 1'b1;
    end
  end

  // Blocked pulses are dropped outright; the FSM above never sees block_input.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      keycode   <= KEY_NONE;
      is_repeat <= 1'b0;
    end else begin
      keycode   <= (emit && !block_input) ? key_q : KEY_NONE;
      is_repeat <= emit_repeat && !block_input;
    end
  end

endmodule

// File: tb/tb_key_repeat_filter.sv
// Bench for key_repeat_filter: directed scenarios with literal pulse counts,
// then randomized keys/ticks/blocking checked every cycle against a model.
module tb_key_repeat_filter;

  localparam int DAS = 10;
  localparam int ARR = 3;

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] keycode_in = 8'h00;
  logic       frame_tick = 1'b0;
  logic       block_input = 1'b0;
  logic [7:0] keycode;
  logic       is_repeat;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int press_cnt = 0;
  int rep_cnt = 0;
  bit checking = 1'b0;

  logic [7:0] exp_key;
  logic       exp_rep;
  logic [7:0] m_q;
  logic [7:0] m_prev;
  logic [7:0] m_emit;
  logic       m_emit_rep;
  int         m_ticks;

  key_repeat_filter #(
    .DAS_FRAMES(DAS),
    .ARR_FRAMES(ARR),
    .CNT_W(6)
  ) dut (
    .Clk(Clk),
    .reset(reset),
    .keycode_in(keycode_in),
    .frame_tick(frame_tick),
    .block_input(block_input),
    .keycode(keycode),
    .is_repeat(is_repeat)
  );

  always #5 Clk = ~Clk;

  function automatic bit model_repeatable(input logic [7:0] k);
    return (k == 8'h04) || (k == 8'h07) || (k == 8'h16);
  endfunction

  // Reference: count ticks since the press; repeats land on tick DAS, DAS+ARR, ...
  always @(posedge Clk or posedge reset) begin
    if (reset) begin
      m_q     <= 8'h00;
      m_prev  <= 8'h00;
      exp_key <= 8'h00;
      exp_rep <= 1'b0;
      m_ticks = 0;
    end else begin
      m_emit     = 8'h00;
      m_emit_rep = 1'b0;
      if (m_q == 8'h00) begin
        m_ticks = 0;
      end else if (m_q != m_prev) begin
        m_emit  = m_q;
        m_ticks = 0;
      end else if (frame_tick) begin
        m_ticks = m_ticks + 1;
        if (model_repeatable(m_q) && m_ticks >= DAS && ((m_ticks - DAS) % ARR) == 0) begin
          m_emit     = m_q;
          m_emit_rep = 1'b1;
        end
      end
      exp_key <= block_input ? 8'h00 : m_emit;
      exp_rep <= !block_input && m_emit_rep;
      m_prev  <= m_q;
      m_q     <= keycode_in;
    end
  end

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
  endtask

  always @(negedge Clk) begin
    if (checking) begin
      check_output("keycode", keycode, exp_key);
      check_output("is_repeat", {7'd0, is_repeat}, {7'd0, exp_rep});
    end
    if (keycode != 8'h00) begin
      if (is_repeat) rep_cnt++;
      else press_cnt++;
    end
  end

  // Holds inputs for n cycles with a frame tick every 4th cycle.
  task automatic apply_stimulus(input logic [7:0] key, input int n, input logic blk);
    for (int i = 0; i < n; i++) begin
      keycode_in  = key;
      block_input = blk;
      frame_tick  = (cyc % 4) == 3;
      @(posedge Clk);
      #1;
      cyc++;
    end
  endtask

  task automatic check_counts(input string name, input int p0, input int r0,
                              input int exp_p, input int exp_r);
    check_output({name, "_presses"}, 8'(press_cnt - p0), 8'(exp_p));
    check_output({name, "_repeats"}, 8'(rep_cnt - r0), 8'(exp_r));
  endtask

  initial begin
    int p0;
    int r0;
    logic [7:0] key;
    int len;

    repeat (3) @(posedge Clk);
    #1;
    checking = 1'b1;
    @(negedge Clk);
    check_output("reset_keycode", keycode, 8'h00);
    check_output("reset_is_repeat", {7'd0, is_repeat}, 8'h00);
    @(posedge Clk);
    #1;
    reset = 1'b0;
    apply_stimulus(8'h00, 4, 1'b0);

    $display("[TB] tap 04");
    p0 = press_cnt; r0 = rep_cnt;
    apply_stimulus(8'h04, 1, 1'b0);
    @(negedge Clk);
    check_output("tap_not_yet", keycode, 8'h00);
    apply_stimulus(8'h04, 1, 1'b0);
    @(negedge Clk);
    check_output("tap_pulse", keycode, 8'h04);
    check_output("tap_pulse_rep", {7'd0, is_repeat}, 8'h00);
    apply_stimulus(8'h04, 1, 1'b0);
    apply_stimulus(8'h00, 20, 1'b0);
    check_counts("tap", p0, r0, 1, 0);

    $display("[TB] hold 07");
    p0 = press_cnt; r0 = rep_cnt;
    apply_stimulus(8'h07, 118, 1'b0);
    apply_stimulus(8'h00, 8, 1'b0);
    check_counts("hold07", p0, r0, 1, 7);

    $display("[TB] hold 1A twice");
    p0 = press_cnt; r0 = rep_cnt;
    apply_stimulus(8'h1A, 118, 1'b0);
    apply_stimulus(8'h00, 8, 1'b0);
    check_counts("rot1", p0, r0, 1, 0);
    p0 = press_cnt; r0 = rep_cnt;
    apply_stimulus(8'h1A, 20, 1'b0);
    apply_stimulus(8'h00, 8, 1'b0);
    check_counts("rot2", p0, r0, 1, 0);

    $display("[TB] switch 04 to 07");
    p0 = press_cnt; r0 = rep_cnt;
    apply_stimulus(8'h04, 20, 1'b0);
    apply_stimulus(8'h07, 60, 1'b0);
    apply_stimulus(8'h00, 8, 1'b0);
    check_counts("switch", p0, r0, 2, 2);

    $display("[TB] hold 04 with block_input window");
    apply_stimulus(8'h04, 30, 1'b0);
    apply_stimulus(8'h04, 32, 1'b1);
    apply_stimulus(8'h04, 56, 1'b0);
    apply_stimulus(8'h00, 8, 1'b0);

    $display("[TB] reset mid-hold");
    apply_stimulus(8'h04, 50, 1'b0);
    reset = 1'b1;
    apply_stimulus(8'h04, 3, 1'b0);
    @(negedge Clk);
    check_output("in_reset_keycode", keycode, 8'h00);
    reset = 1'b0;
    apply_stimulus(8'h04, 2, 1'b0);
    @(negedge Clk);
    check_output("post_reset_pulse", keycode, 8'h04);
    check_output("post_reset_rep", {7'd0, is_repeat}, 8'h00);
    apply_stimulus(8'h04, 60, 1'b0);
    apply_stimulus(8'h00, 8, 1'b0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0: key = 8'h00;
        1: key = 8'h04;
        2: key = 8'h07;
        3: key = 8'h16;
        4: key = 8'h1A;
        5: key = 8'h06;
        6: key = 8'($urandom_range(1, 255));
        default: key = 8'h04;
      endcase
      len = $urandom_range(1, 80);
      for (int j = 0; j < len; j++) begin
        keycode_in  = key;
        frame_tick  = $urandom_range(0, 2) == 0;
        block_input = $urandom_range(0, 7) == 0;
        @(posedge Clk);
        #1;
        cyc++;
      end
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        @(posedge Clk);
        #1;
        cyc++;
        reset = 1'b0;
      end
    end
    apply_stimulus(8'h00, 4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_repeat_filter.md
# key_repeat_filter

Conditions the raw USB keyboard keycode into single-cycle action pulses for the piece-position and rotation logic downstream. A held movement key fires once immediately, then auto-repeats after a frame-counted delay (DAS) at a fixed frame-counted rate (ARR). Rotate and swap fire exactly once per press. Without this block, a held key would move or rotate the piece on every clock.

## Interface
- DAS_FRAMES, 10, frame ticks between the initial pulse and the first repeat (≥1)
- ARR_FRAMES, 3, frame ticks between successive repeats (≥1)
- CNT_W, 6, frame counter width; must hold max(DAS_FRAMES, ARR_FRAMES)−1
- Clk  in  1  system clock; the single clock domain
- reset  in  1  asynchronous, active-high; clears all state
- keycode_in  in  8  raw keycode from the USB host; 8'h00 = no key
- frame_tick  in  1  one-cycle pulse per video frame
- block_input  in  1  suppresses output pulses (spawn/lock phases); the FSM keeps running
- keycode  out  8  conditioned keycode; nonzero for exactly one cycle per action, else 8'h00
- is_repeat  out  1  high together with a nonzero keycode when the pulse is an auto-repeat

## Operation
- Input stage: key_q <= keycode_in every cycle. All decisions use key_q, and key_prev holds the key_q value from the previous cycle.
- Repeatable keys: KEY_LEFT 8'h04, KEY_RIGHT 8'h07, KEY_SOFTDROP 8'h16. Every other nonzero code is one-shot (KEY_ROTATE 8'h1A, KEY_SWAP 8'h06, and others).
- States: IDLE, DELAY, REPEAT, HOLD.
- New press: key_q ≠ 0 and key_q ≠ key_prev, evaluated in any state.
  - Emit key_q with is_repeat=0 and clear the counter.
  - Go to DELAY if the key is repeatable, else HOLD.
- Release: key_q == 0 in any state.
  - Go to IDLE, clear the counter, emit nothing.
- DELAY, on frame_tick:
  - If count == DAS_FRAMES−1: emit key_q with is_repeat=1, clear the counter, go to REPEAT.
  - Else: count++.
- REPEAT, on frame_tick:
  - If count == ARR_FRAMES−1: emit with is_repeat=1 and clear the counter.
  - Else: count++.
- HOLD: no output until release or a different key.
- Emit means keycode/is_repeat are registered with the value for one cycle. They return to 0 the next cycle unless another emit occurs.
- block_input: while high, keycode and is_repeat are forced to 0. State transitions and counting proceed unchanged. A suppressed pulse is dropped, never deferred.

## Timing
- Reset values: keycode=8'h00, is_repeat=0, key_q=key_prev=8'h00, state=IDLE, count=0.
- Latency: keycode_in changes before edge N; key_q updates at edge N; keycode is valid after edge N+1 for one cycle.
- First repeat: the DAS_FRAMES-th frame_tick after the press pulse. Subsequent repeats: every ARR_FRAMES ticks.
- A frame_tick in the same cycle as a new-press detection is ignored, because the new press wins and clears the counter. A frame_tick in the same cycle as a release is also ignored.
- Key change A→B without passing through 0 counts as a new press of B; A's timing is discarded.
- Reset asserted mid-hold: everything clears. After deassert, a still-held key is seen as a new press and pulses 2 cycles later.
- The counter never wraps, because it is cleared at the terminal value.
- frame_tick asserted on consecutive cycles is legal; each cycle counts.

## Structure
- Shared package tetris_pkg holds:
  - key constants KEY_NONE, KEY_LEFT, KEY_RIGHT, KEY_ROTATE, KEY_SWAP, KEY_SOFTDROP;
  - enum key_rep_state_t {IDLE, DELAY, REPEAT, HOLD};
  - function is_repeatable(logic [7:0]).
- The block is one module with no sub-module. The frame counter is a single always_ff inside it.

## Test plan
All scenarios use DAS_FRAMES=10 and ARR_FRAMES=3, with frame_tick every 4 cycles.
- Tap 8'h04 for 3 cycles, then 0 -> exactly one pulse of 8'h04 with is_repeat=0, 2 cycles after the input change; no further pulses.
- Hold 8'h07 for 30 ticks -> 1 initial pulse, then a repeat at tick 10 and at every 3 ticks after (ticks 10, 13, …, 28): 7 repeats, all with is_repeat=1.
- Hold 8'h1A for 30 ticks -> exactly one pulse of 8'h1A. Release and press again -> a second single pulse.
- Hold 8'h04, then switch directly to 8'h07 at tick 5 -> an 8'h07 pulse at once with is_repeat=0; the first 8'h07 repeat comes 10 ticks later, not at tick 10 of the original press.
- Hold 8'h04 with block_input high from tick 8 to tick 15 -> the repeats at ticks 10 and 13 are absent from the output; the repeat at tick 16 appears on schedule.
- Assert reset at tick 12 while holding 8'h04, then deassert -> outputs read 0 during reset; a fresh 8'h04 pulse with is_repeat=0 appears 2 cycles after deassert, and DAS restarts.
